// File: rtl/bcd_mod_counter_if.sv
// Control and data bundle for bcd_mod_counter.
// The master drives the controls and din; the slave returns q, co and load_err.
interface bcd_mod_counter_if #(
  parameter int DIGITS = 2
);
  logic                  clr;
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   din;
  logic [4*DIGITS-1:0]   q;
  logic                  co;
  logic                  load_err;

  modport master (output clr, en, up, load, din, input q, co, load_err);
  modport slave  (input clr, en, up, load, din, output q, co, load_err);
endinterface

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD up/down counter with programmable modulus, validated load
// and a combinational terminal count so that stages cascade on one clock.
module bcd_mod_counter #(
  parameter int DIGITS = 2,
  parameter int MOD    = 60
) (
  input  logic              clk,
  input  logic              clr_n,
  bcd_mod_counter_if.slave  bus
);

  localparam int W = 4 * DIGITS;

  if (DIGITS < 1 || DIGITS > 4 || MOD < 2 || MOD > 10 ** DIGITS) begin : g_cfg_err
    $error("bcd_mod_counter: MOD=%0d is illegal for DIGITS=%0d", MOD, DIGITS);
  end

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           rem;
    r   = '0;
    rem = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  function automatic logic din_ok(input logic [W-1:0] d);
    int   val;
    logic ok;
    val = 0;
    ok  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (d[4*k +: 4] > 4'd9) ok = 1'b0;
      val = val * 10 + int'(d[4*k +: 4]);
    end
    return ok && (val < MOD);
  endfunction

  // Digit-wise ripple; the modulus wrap is applied on top of these.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (c) begin
        if (v[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (b) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          b           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [W-1:0] TOP = to_bcd(MOD - 1);

  logic [W-1:0] q_r, q_next;
  logic         err_r, err_next;
  logic         at_top, at_zero;

  assign at_top  = (q_r == TOP);
  assign at_zero = (q_r == '0);

  always_comb begin
    q_next   = q_r;
    err_next = 1'b0;
    if (bus.clr) begin
      q_next = '0;
    end else if (bus.load) begin
      if (din_ok(bus.din)) q_next = bus.din;
      else                 err_next = 1'b1;
    end else if (bus.en) begin
      if (bus.up) q_next = at_top  ? '0  : bcd_inc(q_r);
      else        q_next = at_zero ? TOP : bcd_dec(q_r);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_r   <= '0;
      err_r <= 1'b0;
    end else begin
      q_r   <= q_next;
      err_r <= err_next;
    end
  end

  assign bus.q        = q_r;
  assign bus.load_err = err_r;
  assign bus.co       = bus.en & ~bus.clr & ~bus.load &
                        ((bus.up & at_top) | (~bus.up & at_zero));

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: five instances (60, 24, decade, and a seconds->minutes
// cascade) share controls and are compared against an integer reference model.
module tb_bcd_mod_counter;

  localparam int N = 5;

  typedef struct packed {
    logic [N-1:0][7:0] q;
    logic [N-1:0]      co;
    logic [N-1:0]      err;
  } exp_t;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  logic clr = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [N-1:0][7:0] din_v = '0;

  int mods [N] = '{60, 24, 10, 60, 60};
  int digs [N] = '{2, 2, 1, 2, 2};
  int val  [N] = '{0, 0, 0, 0, 0};

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  bcd_mod_counter_if #(.DIGITS(2)) if0 ();
  bcd_mod_counter_if #(.DIGITS(2)) if1 ();
  bcd_mod_counter_if #(.DIGITS(1)) if2 ();
  bcd_mod_counter_if #(.DIGITS(2)) if3 ();
  bcd_mod_counter_if #(.DIGITS(2)) if4 ();

  assign if0.clr = clr;  assign if0.en = en;  assign if0.up = up;  assign if0.load = load;
  assign if1.clr = clr;  assign if1.en = en;  assign if1.up = up;  assign if1.load = load;
  assign if2.clr = clr;  assign if2.en = en;  assign if2.up = up;  assign if2.load = load;
  assign if3.clr = clr;  assign if3.en = en;  assign if3.up = up;  assign if3.load = load;
  assign if4.clr = clr;  assign if4.en = if3.co; assign if4.up = up; assign if4.load = load;
  assign if0.din = din_v[0];
  assign if1.din = din_v[1];
  assign if2.din = din_v[2][3:0];
  assign if3.din = din_v[3];
  assign if4.din = din_v[4];

  bcd_mod_counter #(.DIGITS(2), .MOD(60)) u_sec60 (.clk(clk), .clr_n(clr_n), .bus(if0.slave));
  bcd_mod_counter #(.DIGITS(2), .MOD(24)) u_hrs24 (.clk(clk), .clr_n(clr_n), .bus(if1.slave));
  bcd_mod_counter #(.DIGITS(1), .MOD(10)) u_dec10 (.clk(clk), .clr_n(clr_n), .bus(if2.slave));
  bcd_mod_counter #(.DIGITS(2), .MOD(60)) u_cas_s (.clk(clk), .clr_n(clr_n), .bus(if3.slave));
  bcd_mod_counter #(.DIGITS(2), .MOD(60)) u_cas_m (.clk(clk), .clr_n(clr_n), .bus(if4.slave));

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic logic [N-1:0][7:0] get_q();
    return {if4.q, if3.q, {4'h0, if2.q}, if1.q, if0.q};
  endfunction

  function automatic logic [N-1:0] get_co();
    return {if4.co, if3.co, if2.co, if1.co, if0.co};
  endfunction

  function automatic logic [N-1:0] get_err();
    return {if4.load_err, if3.load_err, if2.load_err, if1.load_err, if0.load_err};
  endfunction

  // Drive one cycle of controls and push what the counters must show for it.
  task automatic apply(input bit c, input bit l, input bit e, input bit u,
                       input logic [N-1:0][7:0] d);
    exp_t x;
    bit   en_i, co3;
    int   hi, lo;
    @(posedge clk);
    #2;
    clr = c; load = l; en = e; up = u; din_v = d;
    co3 = 1'b0;
    x   = '0;
    for (int i = 0; i < N; i++) begin
      en_i = (i == 4) ? co3 : e;
      x.co[i] = en_i && !c && !l &&
                ((u && val[i] == mods[i] - 1) || (!u && val[i] == 0));
      if (i == 3) co3 = x.co[i];
      if (c) begin
        val[i] = 0;
      end else if (l) begin
        lo = int'(d[i][3:0]);
        hi = (digs[i] == 2) ? int'(d[i][7:4]) : 0;
        if (lo <= 9 && hi <= 9 && hi * 10 + lo < mods[i]) val[i] = hi * 10 + lo;
        else x.err[i] = 1'b1;
      end else if (en_i) begin
        val[i] = u ? (val[i] + 1) % mods[i] : (val[i] + mods[i] - 1) % mods[i];
      end
      x.q[i] = 8'((val[i] / 10) * 16 + val[i] % 10);
    end
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    logic [N-1:0][7:0] qa;
    logic [N-1:0] ca, ea;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x  = sb[0];
        ca = get_co();
        for (int i = 0; i < N; i++) chk($sformatf("co%0d", i), 32'(ca[i]), 32'(x.co[i]));
        @(posedge clk);
        #1;
        x  = sb.pop_front();
        qa = get_q();
        ea = get_err();
        for (int i = 0; i < N; i++) begin
          chk($sformatf("q%0d", i), 32'(qa[i]), 32'(x.q[i]));
          chk($sformatf("load_err%0d", i), 32'(ea[i]), 32'(x.err[i]));
        end
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0][7:0] d;
    logic [N-1:0][7:0] qa;
    logic [N-1:0] ca, ea;
    #12 clr_n = 1'b1;

    // Reset values after release, then load 37 and step once.
    d = {N{8'h37}};
    apply(0, 0, 0, 1, d);
    apply(0, 1, 0, 1, d);
    apply(0, 0, 1, 1, d);

    // Asynchronous reset mid-count: q clears with no clock edge; co = en & ~up.
    @(posedge clk);
    #3;
    en = 1'b1; up = 1'b0; clr = 1'b0; load = 1'b0;
    clr_n = 1'b0;
    #1;
    qa = get_q(); ca = get_co(); ea = get_err();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_q%0d", i), 32'(qa[i]), 32'h0);
      chk($sformatf("rst_err%0d", i), 32'(ea[i]), 32'h0);
      chk($sformatf("rst_co%0d", i), 32'(ca[i]), 32'h1);
      val[i] = 0;
    end
    en = 1'b0;
    #1 clr_n = 1'b1;

    // Full up sweep through both wraps and the cascade carry.
    for (int k = 0; k < 61; k++) apply(0, 0, 1, 1, d);

    // Down from 10 through borrow and the wrap at 00.
    d = {N{8'h10}};
    apply(0, 1, 0, 0, d);
    for (int k = 0; k < 12; k++) apply(0, 0, 1, 0, d);

    // Hours boundary and rejected loads.
    d = {N{8'h22}};
    apply(0, 1, 0, 1, d);
    for (int k = 0; k < 3; k++) apply(0, 0, 1, 1, d);
    d = {N{8'h24}};
    apply(0, 1, 1, 1, d);
    d = {N{8'h1A}};
    apply(0, 1, 0, 1, d);
    apply(0, 0, 0, 1, d);

    // Priority: clr over load over en.
    d = {N{8'h30}};
    apply(0, 1, 0, 1, d);
    d = {N{8'h45}};
    apply(1, 1, 1, 1, d);
    apply(0, 1, 1, 1, d);

    // Cascade 00:59 -> 01:00 on one edge, then hold.
    d = {8'h00, 8'h59, 8'h00, 8'h00, 8'h00};
    apply(0, 1, 0, 1, d);
    apply(0, 0, 1, 1, d);
    for (int k = 0; k < 5; k++) apply(0, 0, 0, 1, d);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1)
          d[i] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        else
          d[i] = 8'($urandom);
      end
      apply($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, d);
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    chk("drain", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Parametrised multi-digit BCD counter with a programmable modulus: MOD=60 for seconds/minutes, MOD=24 for hours, MOD=10 for a single decade.
- Supports up/down counting, synchronous clear, validated parallel load (time-set), and a combinational terminal-count output so instances cascade on one clock.
- Replaces the single-decade counter in the clock datapath. Outputs feed the 7-segment display mux directly.

Parameters:
- DIGITS, 2, number of BCD digits; q width is 4*DIGITS; legal range 1..4.
- MOD, 60, count modulus; sequence is 0..MOD-1 in decimal; legal range 2..10^DIGITS.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr_n  input  1  asynchronous active-low reset; forces all state to reset values immediately.
- clr  input  1  synchronous clear, active-high; highest-priority synchronous control.
- en  input  1  count enable, active-high; counter holds when low.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel-load strobe, active-high.
- din  input  4*DIGITS  BCD load value; digit k is bits [4k+3:4k], digit 0 is least significant.
- q  output  4*DIGITS  current count in BCD, same digit packing as din.
- co  output  1  terminal count / carry-borrow; combinational.
- load_err  output  1  registered one-cycle pulse flagging a rejected load.

Behaviour:
- Reset:
  - clr_n low -> q = 0, load_err = 0, asynchronously, regardless of clk.
  - co follows its equation, so co = en & ~up while in reset.
  - Release of clr_n is recognised on the next clk edge.
- Synchronous priority per edge: clr > load > en > hold.
- clr=1 -> q <= 0 and load_err <= 0. Any load or en in the same cycle is ignored.
- load=1 (clr=0):
  - din is valid if every digit is <= 9 AND its decimal value is < MOD.
  - Valid -> q <= din, load_err <= 0.
  - Invalid -> q holds, load_err <= 1 for exactly that cycle.
  - en is ignored in any load cycle.
- Count (en=1, clr=0, load=0):
  - up=1: if q == MOD-1 then q <= 0, else q <= q+1.
  - up=0: if q == 0 then q <= MOD-1, else q <= q-1.
  - All arithmetic is per-digit BCD with internal ripple: a digit at 9 going up wraps to 0 and increments the next digit; a digit at 0 going down wraps to 9 and decrements the next digit.
  - The modulus check overrides digit ripple. Example: MOD=24, q=23, up -> 00, never 24.
- Hold: en=0 -> q unchanged.
- load_err <= 0 in every cycle that is not a rejected load.
- co = en & ~clr & ~load & ((up & q == MOD-1) | (~up & q == 0)).
  - Purely combinational, no register stage.
  - Cascading: the next stage's en is driven from this stage's co, so the higher stage steps on the same edge as this stage wraps.
- Illegal internal state (a digit > 9) is unreachable: reset, clear and validated load are the only entry points.
- Mid-operation clr_n assertion: the count is lost and q = 0 immediately. No pending load or error survives.
- Parameter legality:
  - MOD > 10^DIGITS or MOD < 2 is a configuration error.
  - The RTL flags it with an elaboration-time check (generate-block error) rather than silently truncating.

Test Plan:
- Reset and wrap (DIGITS=2, MOD=60): assert clr_n=0 mid-count at q=37 -> q=00 immediately. Release, en=1, up=1 for 60 cycles -> q steps 00..59 with BCD digit carries at 09->10 and 49->50. co=1 only while q=59. Next edge -> q=00.
- Down wrap and borrow (DIGITS=2, MOD=60): load 0x10, then en=1, up=0 -> 09. Continue to 00, where co=1. Next edge -> 59.
- Hours modulus (DIGITS=2, MOD=24): count up from 0x22 -> 23, then 00 with co=1 at 23. Then load 0x24 -> q holds, load_err=1 for one cycle. Then load 0x1A -> rejected (digit > 9), load_err=1.
- Priority: in one cycle drive clr=1, load=1 din=0x45, en=1 at q=0x30 -> q=00, load_err=0, co=0. Next cycle load=1 din=0x45, en=1 -> q=45, not 46, and co=0.
- Cascade: seconds MOD=60 co drives minutes MOD=60 en. Load 00:59 and run one enabled cycle -> 01:00 on the same edge. Hold en=0 for 5 cycles -> q unchanged, co=0.
- Single decade (DIGITS=1, MOD=10): up-count 0..9..0 matches the legacy decade counter. co=1 at 9, and at 0 when up=0.
